// File: rtl/instr_encoder_if.sv
// Decoded-instruction record types and the stream/status interface of instr_encoder.
// The record carries a kind plus a union of per-kind payload layouts.
package instr_types_pkg;

   localparam logic [2:0] K_OP_IMM = 3'd0;
   localparam logic [2:0] K_LUI    = 3'd1;

   localparam logic [3:0] FK_ADD  = 4'd0;
   localparam logic [3:0] FK_SUB  = 4'd1;
   localparam logic [3:0] FK_SLL  = 4'd2;
   localparam logic [3:0] FK_SLT  = 4'd3;
   localparam logic [3:0] FK_SLTU = 4'd4;
   localparam logic [3:0] FK_XOR  = 4'd5;
   localparam logic [3:0] FK_SRL  = 4'd6;
   localparam logic [3:0] FK_SRA  = 4'd7;
   localparam logic [3:0] FK_OR   = 4'd8;
   localparam logic [3:0] FK_AND  = 4'd9;

   typedef struct packed {
      logic [3:0]  func;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [31:0] imm;
   } t_op_imm_data;

   typedef struct packed {
      logic [3:0]  rsvd_hi;
      logic [4:0]  rd;
      logic [4:0]  rsvd_lo;
      logic [31:0] imm;
   } t_lui_data;

   typedef union packed {
      t_op_imm_data op_imm;
      t_lui_data    lui;
   } t_instr_data;

   typedef struct packed {
      logic [2:0]  kind;
      t_instr_data data;
   } t_decoded_instr;

endpackage

interface instr_encoder_if #(
   parameter int ADDR_W    = 32,
   parameter int ERR_CNT_W = 8
);
   import instr_types_pkg::*;

   logic                 start;
   logic                 in_valid;
   logic                 in_ready;
   t_decoded_instr       in_instr;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_word;
   logic [ADDR_W-1:0]    out_addr;
   logic                 err_valid;
   logic [1:0]           err_code;
   logic [ADDR_W-3:0]    word_count;
   logic [ERR_CNT_W-1:0] err_count;

   modport slave (
      input  start, in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_word, out_addr,
             err_valid, err_code, word_count, err_count
   );

   modport master (
      output start, in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_word, out_addr,
             err_valid, err_code, word_count, err_count
   );

endinterface

// File: rtl/instr_encoder.sv
// Turns decoded OP_IMM/LUI records back into RV32I machine words with sequential
// byte addresses; unencodable records are consumed and reported instead of emitted.
module instr_encoder
   import instr_types_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          ERR_CNT_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   instr_encoder_if.slave  bus
);

   localparam int                WC_W      = ADDR_W - 2;
   localparam logic [ADDR_W-1:0] BASE_S    = BASE_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

   logic                 valid_q,      valid_d;
   logic [31:0]          word_q,       word_d;
   logic [ADDR_W-1:0]    addr_q,       addr_d;
   logic [ADDR_W-1:0]    cnt_q,        cnt_d;
   logic                 err_valid_q,  err_valid_d;
   logic [1:0]           err_code_q,   err_code_d;
   logic [WC_W-1:0]      word_count_q, word_count_d;
   logic [ERR_CNT_W-1:0] err_count_q,  err_count_d;

   t_op_imm_data      op_s;
   t_lui_data         lui_s;
   logic [31:0]       imm_sext_s;
   logic [2:0]        funct3_s;
   logic [6:0]        shift_hi_s;
   logic              is_arith_s;
   logic              is_shift_s;
   logic [31:0]       enc_word_s;
   logic              enc_ok_s;
   logic [1:0]        enc_code_s;
   logic              in_ready_s;
   logic              accept_s;
   logic              load_s;
   logic              reject_s;
   logic              out_hs_s;
   logic [ADDR_W-1:0] cnt_base_s;

   // Classify the OP_IMM function and look up its funct3 / shift-type bits.
   always_comb begin
      op_s       = bus.in_instr.data.op_imm;
      funct3_s   = 3'b000;
      shift_hi_s = 7'b0000000;
      is_arith_s = 1'b0;
      is_shift_s = 1'b0;
      case (op_s.func)
         FK_ADD:  begin funct3_s = 3'b000; is_arith_s = 1'b1; end
         FK_SLT:  begin funct3_s = 3'b010; is_arith_s = 1'b1; end
         FK_SLTU: begin funct3_s = 3'b011; is_arith_s = 1'b1; end
         FK_XOR:  begin funct3_s = 3'b100; is_arith_s = 1'b1; end
         FK_OR:   begin funct3_s = 3'b110; is_arith_s = 1'b1; end
         FK_AND:  begin funct3_s = 3'b111; is_arith_s = 1'b1; end
         FK_SLL:  begin funct3_s = 3'b001; is_shift_s = 1'b1; end
         FK_SRL:  begin funct3_s = 3'b101; is_shift_s = 1'b1; end
         FK_SRA:  begin funct3_s = 3'b101; is_shift_s = 1'b1; shift_hi_s = 7'b0100000; end
         FK_SUB:  begin funct3_s = 3'b000; end
         default: begin funct3_s = 3'b000; end
      endcase
   end

   // Build the machine word and decide whether the record is encodable.
   always_comb begin
      lui_s      = bus.in_instr.data.lui;
      imm_sext_s = {{20{op_s.imm[11]}}, op_s.imm[11:0]};
      enc_word_s = 32'h0000_0000;
      enc_ok_s   = 1'b0;
      enc_code_s = 2'd0;
      if ((bus.in_instr.kind == K_OP_IMM) && is_arith_s) begin
         if (op_s.imm == imm_sext_s) begin
            enc_ok_s   = 1'b1;
            enc_word_s = {op_s.imm[11:0], op_s.rs1, funct3_s, op_s.rd, 7'b0010011};
         end else begin
            enc_code_s = 2'd1;
         end
      end else if ((bus.in_instr.kind == K_OP_IMM) && is_shift_s) begin
         if (op_s.imm[31:5] == 27'd0) begin
            enc_ok_s   = 1'b1;
            enc_word_s = {shift_hi_s, op_s.imm[4:0], op_s.rs1, funct3_s, op_s.rd, 7'b0010011};
         end else begin
            enc_code_s = 2'd2;
         end
      end else if (bus.in_instr.kind == K_LUI) begin
         if (lui_s.imm[11:0] == 12'd0) begin
            enc_ok_s   = 1'b1;
            enc_word_s = {lui_s.imm[31:12], lui_s.rd, 7'b0110111};
         end else begin
            enc_code_s = 2'd3;
         end
      end else begin
         enc_code_s = 2'd0;
      end
   end

   // Handshake resolution and next-state for the output stage and counters.
   always_comb begin
      in_ready_s = !valid_q || bus.out_ready;
      accept_s   = bus.in_valid && in_ready_s;
      load_s     = accept_s && enc_ok_s;
      reject_s   = accept_s && !enc_ok_s;
      out_hs_s   = valid_q && bus.out_ready;
      // start reloads the counter before any same-edge accept consumes it
      cnt_base_s = bus.start ? BASE_S : cnt_q;

      valid_d = valid_q;
      word_d  = word_q;
      addr_d  = addr_q;
      if (load_s) begin
         valid_d = 1'b1;
         word_d  = enc_word_s;
         addr_d  = cnt_base_s;
      end else if (out_hs_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (load_s) begin
         cnt_d = cnt_base_s + ADDR_STEP;
      end else begin
         cnt_d = cnt_base_s;
      end

      err_valid_d = reject_s;
      if (reject_s) begin
         err_code_d = enc_code_s;
      end else begin
         err_code_d = err_code_q;
      end

      if (bus.start) begin
         word_count_d = {WC_W{1'b0}};
      end else if (out_hs_s) begin
         word_count_d = word_count_q + WC_W'(1);
      end else begin
         word_count_d = word_count_q;
      end

      if (bus.start) begin
         err_count_d = {ERR_CNT_W{1'b0}};
      end else if (reject_s && !(&err_count_q)) begin
         err_count_d = err_count_q + ERR_CNT_W'(1);
      end else begin
         err_count_d = err_count_q;
      end
   end

   // State registers; reset drops any held word immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= 1'b0;
         word_q       <= 32'h0000_0000;
         addr_q       <= BASE_S;
         cnt_q        <= BASE_S;
         err_valid_q  <= 1'b0;
         err_code_q   <= 2'd0;
         word_count_q <= {WC_W{1'b0}};
         err_count_q  <= {ERR_CNT_W{1'b0}};
      end else begin
         valid_q      <= valid_d;
         word_q       <= word_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         err_valid_q  <= err_valid_d;
         err_code_q   <= err_code_d;
         word_count_q <= word_count_d;
         err_count_q  <= err_count_d;
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = valid_q;
   assign bus.out_word   = word_q;
   assign bus.out_addr   = addr_q;
   assign bus.err_valid  = err_valid_q;
   assign bus.err_code   = err_code_q;
   assign bus.word_count = word_count_q;
   assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: one wide instance and one narrow (ADDR_W=4, ERR_CNT_W=2)
// instance share the same stimulus and are checked against a spec-level model.
module tb_instr_encoder;
   import instr_types_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic           start_r     = 1'b0;
   logic           in_valid_r  = 1'b0;
   logic           out_ready_r = 1'b0;
   t_decoded_instr in_instr_r  = '0;

   instr_encoder_if #(.ADDR_W(32), .ERR_CNT_W(8)) bus_a ();
   instr_encoder_if #(.ADDR_W(4),  .ERR_CNT_W(2)) bus_b ();

   assign bus_a.start     = start_r;
   assign bus_a.in_valid  = in_valid_r;
   assign bus_a.in_instr  = in_instr_r;
   assign bus_a.out_ready = out_ready_r;
   assign bus_b.start     = start_r;
   assign bus_b.in_valid  = in_valid_r;
   assign bus_b.in_instr  = in_instr_r;
   assign bus_b.out_ready = out_ready_r;

   instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .ERR_CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a));
   instr_encoder #(.ADDR_W(4), .BASE_ADDR(32'h0000_0000), .ERR_CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b));

   int checks = 0;
   int errors = 0;

   // Reference model state (byte addresses kept as full 32-bit values).
   bit          m_valid;
   logic [31:0] m_word;
   int unsigned m_addr;
   int unsigned m_next;
   int unsigned m_wc;
   int unsigned m_ec;
   bit          m_errv;
   logic [1:0]  m_errc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic t_decoded_instr mk_op(input logic [3:0] f, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [31:0] imm);
      t_decoded_instr r;
      r = '0;
      r.kind = K_OP_IMM;
      r.data.op_imm.func = f;
      r.data.op_imm.rd   = rd;
      r.data.op_imm.rs1  = rs1;
      r.data.op_imm.imm  = imm;
      return r;
   endfunction

   function automatic t_decoded_instr mk_lui(input logic [4:0] rd, input logic [31:0] imm);
      t_decoded_instr r;
      r = '0;
      r.kind = K_LUI;
      r.data.lui.rd  = rd;
      r.data.lui.imm = imm;
      return r;
   endfunction

   // Encoding rules computed with plain integer arithmetic.
   function automatic void model_enc(input t_decoded_instr r, output bit ok,
                                     output logic [1:0] code, output logic [31:0] w);
      int          simm;
      int unsigned uimm, rd, rs1, f3, hi, cls;
      ok = 1'b0; code = 2'd0; w = 32'd0;
      f3 = 0; hi = 0; cls = 0;
      if (r.kind == K_OP_IMM) begin
         uimm = r.data.op_imm.imm;
         simm = $signed(r.data.op_imm.imm);
         rd   = 32'(r.data.op_imm.rd);
         rs1  = 32'(r.data.op_imm.rs1);
         case (r.data.op_imm.func)
            FK_ADD:  begin f3 = 0; cls = 1; end
            FK_SLT:  begin f3 = 2; cls = 1; end
            FK_SLTU: begin f3 = 3; cls = 1; end
            FK_XOR:  begin f3 = 4; cls = 1; end
            FK_OR:   begin f3 = 6; cls = 1; end
            FK_AND:  begin f3 = 7; cls = 1; end
            FK_SLL:  begin f3 = 1; cls = 2; end
            FK_SRL:  begin f3 = 5; cls = 2; end
            FK_SRA:  begin f3 = 5; cls = 2; hi = 32; end
            default: begin cls = 0; end
         endcase
         if (cls == 1) begin
            if (simm >= -2048 && simm <= 2047) begin
               ok = 1'b1;
               w  = ((uimm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end else code = 2'd1;
         end else if (cls == 2) begin
            if (uimm < 32) begin
               ok = 1'b1;
               w  = (hi << 25) | (uimm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end else code = 2'd2;
         end else code = 2'd0;
      end else if (r.kind == K_LUI) begin
         uimm = r.data.lui.imm;
         rd   = 32'(r.data.lui.rd);
         if (uimm % 4096 == 0) begin
            ok = 1'b1;
            w  = uimm | (rd << 7) | 32'h37;
         end else code = 2'd3;
      end else code = 2'd0;
   endfunction

   function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_word = 32'd0; m_addr = 0; m_next = 0;
      m_wc = 0; m_ec = 0; m_errv = 1'b0; m_errc = 2'd0;
   endtask

   task automatic check_outputs();
      chk("out_valid_a", 64'(bus_a.out_valid), 64'(m_valid));
      chk("out_valid_b", 64'(bus_b.out_valid), 64'(m_valid));
      if (m_valid) begin
         chk("out_word_a", 64'(bus_a.out_word), 64'(m_word));
         chk("out_word_b", 64'(bus_b.out_word), 64'(m_word));
         chk("out_addr_a", 64'(bus_a.out_addr), 64'(m_addr));
         chk("out_addr_b", 64'(bus_b.out_addr), 64'(m_addr[3:0]));
      end
      chk("err_valid_a", 64'(bus_a.err_valid), 64'(m_errv));
      chk("err_valid_b", 64'(bus_b.err_valid), 64'(m_errv));
      chk("err_code_a", 64'(bus_a.err_code), 64'(m_errc));
      chk("err_code_b", 64'(bus_b.err_code), 64'(m_errc));
      chk("word_count_a", 64'(bus_a.word_count), 64'(m_wc[29:0]));
      chk("word_count_b", 64'(bus_b.word_count), 64'(m_wc[1:0]));
      chk("err_count_a", 64'(bus_a.err_count), 64'(sat(m_ec, 255)));
      chk("err_count_b", 64'(bus_b.err_count), 64'(sat(m_ec, 3)));
   endtask

   task automatic check_reset();
      chk("rst_in_ready_a", 64'(bus_a.in_ready), 64'd1);
      chk("rst_out_word_a", 64'(bus_a.out_word), 64'd0);
      chk("rst_out_addr_a", 64'(bus_a.out_addr), 64'd0);
      chk("rst_out_word_b", 64'(bus_b.out_word), 64'd0);
      chk("rst_out_addr_b", 64'(bus_b.out_addr), 64'd0);
      check_outputs();
   endtask

   // One clock of stimulus: drive at negedge, check in_ready, update model at posedge, check at negedge.
   task automatic step(input bit v, input t_decoded_instr r, input bit ordy, input bit st);
      bit          exp_rdy, acc, hs, ok;
      logic [1:0]  code;
      logic [31:0] w;
      in_valid_r = v; in_instr_r = r; out_ready_r = ordy; start_r = st;
      #1;
      exp_rdy = !m_valid || ordy;
      chk("in_ready_a", 64'(bus_a.in_ready), 64'(exp_rdy));
      chk("in_ready_b", 64'(bus_b.in_ready), 64'(exp_rdy));
      acc = v && exp_rdy;
      hs  = m_valid && ordy;
      model_enc(r, ok, code, w);
      @(posedge clk);
      if (st) begin m_next = 0; m_wc = 0; m_ec = 0; end
      if (hs) begin m_valid = 1'b0; if (!st) m_wc++; end
      m_errv = 1'b0;
      if (acc) begin
         if (ok) begin
            m_valid = 1'b1; m_word = w; m_addr = m_next; m_next = m_next + 4;
         end else begin
            m_errv = 1'b1; m_errc = code;
            if (!st) m_ec++;
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   function automatic t_decoded_instr rand_rec();
      t_decoded_instr r;
      logic [63:0]    raw;
      logic [3:0]     f;
      logic [4:0]     rd, rs1;
      int unsigned    cat;
      raw = {$urandom, $urandom};
      r   = raw[$bits(t_decoded_instr)-1:0];
      rd  = 5'($urandom); rs1 = 5'($urandom);
      cat = $urandom_range(0, 9);
      case (cat)
         0, 8: begin
            case ($urandom_range(0, 5))
               0: f = FK_ADD; 1: f = FK_SLT; 2: f = FK_SLTU;
               3: f = FK_XOR; 4: f = FK_OR; default: f = FK_AND;
            endcase
            r = mk_op(f, rd, rs1, 32'($urandom_range(0, 4095)) - 32'd2048);
         end
         1: r = mk_op(FK_ADD, rd, rs1, $urandom);
         2: r = mk_op(4'($urandom_range(0, 2) == 0 ? FK_SLL : ($urandom_range(0, 1) == 0 ? FK_SRL : FK_SRA)),
                      rd, rs1, 32'($urandom_range(0, 31)));
         3: r = mk_op(FK_SRA, rd, rs1, 32'($urandom_range(32, 64)));
         4: r.data.lui.imm = $urandom & 32'hFFFF_F000;
         5: r.kind = K_LUI;
         6: r.kind = K_OP_IMM;
         default: r.kind = 3'($urandom_range(0, 7));
      endcase
      if (cat == 4) r.kind = K_LUI;
      return r;
   endfunction

   logic [3:0]     wrap_exp [5];
   t_decoded_instr nop_r;

   initial begin
      wrap_exp[0] = 4'd0; wrap_exp[1] = 4'd4; wrap_exp[2] = 4'd8;
      wrap_exp[3] = 4'd12; wrap_exp[4] = 4'd0;
      nop_r = mk_op(FK_ADD, 5'd0, 5'd0, 32'd0);
      model_reset();
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      check_reset();
      rst = 1'b0;

      // ADDI x1,x2,-1
      step(1'b1, mk_op(FK_ADD, 5'd1, 5'd2, 32'hFFFF_FFFF), 1'b1, 1'b0);
      chk("addi_word", 64'(bus_a.out_word), 64'h0000_0000_FFF1_0093);
      chk("addi_addr", 64'(bus_a.out_addr), 64'd0);
      step(1'b0, nop_r, 1'b1, 1'b0);
      chk("addi_wc", 64'(bus_a.word_count), 64'd1);

      // Back-to-back SRAI, LUI, SLTIU
      step(1'b1, mk_op(FK_SRA, 5'd3, 5'd4, 32'd5), 1'b1, 1'b0);
      chk("srai_word", 64'(bus_a.out_word), 64'h4052_5193);
      step(1'b1, mk_lui(5'd5, 32'h1234_5000), 1'b1, 1'b0);
      chk("lui_word", 64'(bus_a.out_word), 64'h1234_52B7);
      step(1'b1, mk_op(FK_SLTU, 5'd1, 5'd0, 32'd1), 1'b1, 1'b0);
      chk("sltiu_word", 64'(bus_a.out_word), 64'h0010_3093);
      chk("sltiu_addr", 64'(bus_a.out_addr), 64'd12);

      // Backpressure: hold for 3 cycles, then handshake and reload together
      step(1'b1, mk_op(FK_XOR, 5'd7, 5'd8, 32'd77), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, mk_op(FK_OR, 5'd9, 5'd10, 32'd5), 1'b0, 1'b0);
      chk("hold_in_ready", 64'(bus_a.in_ready), 64'd0);
      step(1'b1, mk_op(FK_OR, 5'd9, 5'd10, 32'd5), 1'b1, 1'b0);
      chk("reload_valid", 64'(bus_a.out_valid), 64'd1);

      // Rejections
      step(1'b1, mk_op(FK_ADD, 5'd1, 5'd1, 32'h0000_0800), 1'b1, 1'b0);
      chk("rej_imm_pulse", 64'(bus_a.err_valid), 64'd1);
      chk("rej_imm_code", 64'(bus_a.err_code), 64'd1);
      chk("rej_imm_noout", 64'(bus_a.out_valid), 64'd0);
      step(1'b1, mk_op(FK_ADD, 5'd2, 5'd2, 32'd3), 1'b1, 1'b0);
      step(1'b1, mk_op(FK_SLL, 5'd1, 5'd1, 32'd32), 1'b1, 1'b0);
      chk("rej_shamt_code", 64'(bus_a.err_code), 64'd2);
      step(1'b1, mk_lui(5'd1, 32'h0000_0001), 1'b1, 1'b0);
      chk("rej_lui_code", 64'(bus_a.err_code), 64'd3);
      step(1'b1, mk_op(FK_SUB, 5'd1, 5'd1, 32'd1), 1'b1, 1'b0);
      chk("rej_sub_code", 64'(bus_a.err_code), 64'd0);
      step(1'b0, nop_r, 1'b1, 1'b0);
      chk("err_code_hold", 64'(bus_a.err_code), 64'd0);
      for (int i = 0; i < 5; i++) step(1'b1, mk_lui(5'd3, 32'h0000_0010), 1'b1, 1'b0);
      chk("err_sat_b", 64'(bus_b.err_count), 64'd3);

      // start with an accept, then address wrap on the narrow instance
      step(1'b0, nop_r, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, mk_op(FK_ADD, 5'(i), 5'(i), 32'(i)), 1'b1, i == 0);
         if (i == 0) begin
            chk("start_wc", 64'(bus_a.word_count), 64'd0);
            chk("start_ec", 64'(bus_a.err_count), 64'd0);
         end
         chk("wrap_addr_b", 64'(bus_b.out_addr), 64'(wrap_exp[i]));
      end

      // Randomised traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, rand_rec(), $urandom_range(0, 9) < 7, 1'b0);

      // Reset while a word is held
      step(1'b1, mk_op(FK_AND, 5'd4, 5'd4, 32'd15), 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_async_valid_a", 64'(bus_a.out_valid), 64'd0);
      chk("rst_async_valid_b", 64'(bus_b.out_valid), 64'd0);
      model_reset();
      @(negedge clk);
      check_reset();
      rst = 1'b0;
      step(1'b1, mk_op(FK_ADD, 5'd1, 5'd2, 32'd1), 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
